// File: rtl/ldb_pkg.sv
// Shared encodings for the load block: FSM states, fixed AXI read attributes
// and the burst-code to arlen mapping.
package ldb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_RD   = 3'd2,
        ST_DONE = 3'd3
    } ldb_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_16B   = 3'd4;

    // Burst code selects 1/2/4/8 beats; arlen is beats minus one.
    function automatic logic [3:0] brst_to_arlen(input logic [1:0] brst);
        case (brst)
            2'b00:   return 4'd0;
            2'b01:   return 4'd1;
            2'b10:   return 4'd3;
            default: return 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/ldb_ur_wr_stage.sv
// Registered UR write port: one write per accepted R beat, address is the
// first UR word plus the beat index, wrapping modulo the UR address space.
module ldb_ur_wr_stage #(
    parameter int UR_ADDR_WIDTH = 11,
    parameter int DATA_WIDTH    = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_beat,
    input  logic [UR_ADDR_WIDTH-1:0] i_base,
    input  logic [2:0]               i_idx,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic                     o_ur_we,
    output logic [UR_ADDR_WIDTH-1:0] o_ur_addr,
    output logic [DATA_WIDTH-1:0]    o_ur_wdata
);

    logic                     we_d, we_q;
    logic [UR_ADDR_WIDTH-1:0] addr_d, addr_q;
    logic [DATA_WIDTH-1:0]    wdata_d, wdata_q;

    always_comb begin
        we_d    = i_beat;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (i_beat) begin
            addr_d  = i_base + UR_ADDR_WIDTH'(i_idx);
            wdata_d = i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_ur_we    = we_q;
    assign o_ur_addr  = addr_q;
    assign o_ur_wdata = wdata_q;

endmodule

// File: rtl/ldb_axi_rd.sv
// Load block: one AXI4 INCR read burst per load instruction, each beat written
// to the UR file. Response checking (o_err) is built only with LDB_RESP_CHECK_EN.
module ldb_axi_rd
    import ldb_pkg::*;
#(
    parameter int UR_ADDR_WIDTH = 11,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_micro_inst_u_valid,
    output logic                     o_micro_inst_u_ready,
    input  logic [1:0]               i_micro_inst_u_brst,
    input  logic [ADDR_WIDTH-1:0]    i_micro_inst_u_gr_base_addr,
    input  logic [3:0]               i_micro_inst_u_ur_id,
    input  logic [UR_ADDR_WIDTH-1:0] i_micro_inst_u_ur_addr,
    output logic                     o_micro_inst_d_valid,
    output logic                     o_micro_inst_d_done,
    output logic                     o_ur_we,
    output logic [UR_ADDR_WIDTH-1:0] o_ur_addr,
    output logic [DATA_WIDTH-1:0]    o_ur_wdata,
    output logic [3:0]               arid,
    output logic                     arvalid,
    output logic [ADDR_WIDTH-1:0]    araddr,
    output logic [3:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic                     rvalid,
    input  logic                     rlast,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    output logic                     rready,
    output logic                     o_err,
    output logic [2:0]               o_state
);

    ldb_state_e               state_d, state_q;
    logic [1:0]               brst_d, brst_q;
    logic [ADDR_WIDTH-1:0]    base_d, base_q;
    logic [3:0]               ur_id_d, ur_id_q;
    logic [UR_ADDR_WIDTH-1:0] ur_addr_d, ur_addr_q;
    logic [2:0]               beat_idx_d, beat_idx_q;
    logic [3:0]               arlen_c;
    logic                     accept;
    logic                     rd_beat;

    assign arlen_c = brst_to_arlen(brst_q);
    assign accept  = (state_q == ST_IDLE) && i_micro_inst_u_valid;
    assign rd_beat = (state_q == ST_RD) && rvalid;

    always_comb begin
        state_d    = state_q;
        brst_d     = brst_q;
        base_d     = base_q;
        ur_id_d    = ur_id_q;
        ur_addr_d  = ur_addr_q;
        beat_idx_d = beat_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (i_micro_inst_u_valid) begin
                    brst_d     = i_micro_inst_u_brst;
                    base_d     = i_micro_inst_u_gr_base_addr;
                    ur_id_d    = i_micro_inst_u_ur_id;
                    ur_addr_d  = i_micro_inst_u_ur_addr;
                    beat_idx_d = 3'd0;
                    state_d    = ST_AR;
                end
            end
            ST_AR: begin
                if (arready) state_d = ST_RD;
            end
            ST_RD: begin
                // rlast alone ends the burst; a count mismatch is only flagged.
                if (rvalid) begin
                    beat_idx_d = beat_idx_q + 3'd1;
                    if (rlast) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            brst_q     <= 2'b00;
            base_q     <= '0;
            ur_id_q    <= 4'd0;
            ur_addr_q  <= '0;
            beat_idx_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            brst_q     <= brst_d;
            base_q     <= base_d;
            ur_id_q    <= ur_id_d;
            ur_addr_q  <= ur_addr_d;
            beat_idx_q <= beat_idx_d;
        end
    end

`ifdef LDB_RESP_CHECK_EN
    logic err_d, err_q;
    logic beat_err;

    assign beat_err = rd_beat &&
                      ((rresp != AXI_RESP_OKAY) || (rid != ur_id_q) ||
                       (rlast && (beat_idx_q != arlen_c[2:0])) ||
                       (!rlast && (beat_idx_q == arlen_c[2:0])));

    always_comb begin
        err_d = err_q;
        if (accept)        err_d = 1'b0;
        else if (beat_err) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign o_err = err_q;
`else
    logic unused_rsp;
    assign unused_rsp = ^{rid, rresp, accept};
    assign o_err      = 1'b0;
`endif

    ldb_ur_wr_stage #(
        .UR_ADDR_WIDTH(UR_ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_wr_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_beat    (rd_beat),
        .i_base    (ur_addr_q),
        .i_idx     (beat_idx_q),
        .i_data    (rdata),
        .o_ur_we   (o_ur_we),
        .o_ur_addr (o_ur_addr),
        .o_ur_wdata(o_ur_wdata)
    );

    // Constant AR attributes are gated so every output reads 0 out of reset.
    assign o_micro_inst_u_ready = (state_q == ST_IDLE);
    assign o_micro_inst_d_valid = (state_q == ST_DONE);
    assign o_micro_inst_d_done  = (state_q == ST_DONE);
    assign arvalid = (state_q == ST_AR);
    assign araddr  = base_q;
    assign arlen   = arlen_c;
    assign arid    = ur_id_q;
    assign arsize  = arvalid ? AXI_SIZE_16B : 3'd0;
    assign arburst = arvalid ? AXI_BURST_INCR : 2'b00;
    assign arlock  = 1'b0;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign rready  = (state_q == ST_RD);
    assign o_state = state_q;

endmodule

// File: tb/tb_ldb_axi_rd.sv
// Directed bench for ldb_axi_rd; o_err expectations follow LDB_RESP_CHECK_EN.
module tb_ldb_axi_rd;

`ifdef LDB_RESP_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         u_valid;
    logic         u_ready;
    logic [1:0]   u_brst;
    logic [31:0]  u_base;
    logic [3:0]   u_id;
    logic [10:0]  u_ur_addr;
    logic         d_valid, d_done;
    logic         ur_we;
    logic [10:0]  ur_addr;
    logic [127:0] ur_wdata;
    logic [3:0]   arid;
    logic         arvalid;
    logic [31:0]  araddr;
    logic [3:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic         arready;
    logic [3:0]   rid;
    logic         rvalid, rlast;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rready;
    logic         o_err;
    logic [2:0]   o_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] cur_id;

    always #5 clk = ~clk;

    ldb_axi_rd dut (
        .clk(clk), .rst_n(rst_n),
        .i_micro_inst_u_valid(u_valid), .o_micro_inst_u_ready(u_ready),
        .i_micro_inst_u_brst(u_brst), .i_micro_inst_u_gr_base_addr(u_base),
        .i_micro_inst_u_ur_id(u_id), .i_micro_inst_u_ur_addr(u_ur_addr),
        .o_micro_inst_d_valid(d_valid), .o_micro_inst_d_done(d_done),
        .o_ur_we(ur_we), .o_ur_addr(ur_addr), .o_ur_wdata(ur_wdata),
        .arid(arid), .arvalid(arvalid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arready(arready),
        .rid(rid), .rvalid(rvalid), .rlast(rlast), .rdata(rdata), .rresp(rresp),
        .rready(rready), .o_err(o_err), .o_state(o_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] brst, input logic [31:0] base,
                         input logic [3:0] id, input logic [10:0] ura);
        logic [3:0] exp_len;
        exp_len   = (4'd1 << brst) - 4'd1;
        u_valid   = 1'b1;
        u_brst    = brst;
        u_base    = base;
        u_id      = id;
        u_ur_addr = ura;
        cur_id    = id;
        for (int i = 0; i < 20 && !u_ready; i++) tick();
        check("u_ready_before_accept", u_ready, 1'b1);
        tick();
        u_valid = 1'b0;
        check("accept_state", o_state, 3'd1);
        check("arvalid", arvalid, 1'b1);
        check("araddr", araddr, base);
        check("arlen", arlen, exp_len);
        check("arid", arid, id);
        check("arsize", arsize, 3'd4);
        check("arburst", arburst, 2'b01);
        check("ar_lock_cache_prot", {arlock, arcache, arprot}, 8'h00);
        check("u_ready_busy", u_ready, 1'b0);
    endtask

    task automatic ar_phase(input int nwait, input logic [31:0] exp_addr, input logic [3:0] exp_len);
        for (int i = 0; i < nwait; i++) begin
            tick();
            check("ar_hold_valid", arvalid, 1'b1);
            check("ar_hold_addr", araddr, exp_addr);
            check("ar_hold_len", arlen, exp_len);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("rd_state", o_state, 3'd2);
        check("rready", rready, 1'b1);
        check("arvalid_drop", arvalid, 1'b0);
    endtask

    task automatic beat(input logic [127:0] d, input logic last, input logic [1:0] resp,
                        input logic [10:0] exp_addr);
        rvalid = 1'b1;
        rdata  = d;
        rlast  = last;
        rresp  = resp;
        rid    = cur_id;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        check("ur_we", ur_we, 1'b1);
        check("ur_addr", ur_addr, exp_addr);
        check("ur_wdata", ur_wdata, d);
        check("d_valid_on_beat", d_valid, last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] a;
        rst_n = 1'b0; u_valid = 1'b0; u_brst = 2'b00; u_base = '0; u_id = '0;
        u_ur_addr = '0; arready = 1'b0; rid = '0; rvalid = 1'b0; rlast = 1'b0;
        rdata = '0; rresp = 2'b00; cur_id = '0;

        // Reset state
        repeat (3) tick();
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_ur_we", ur_we, 1'b0);
        check("rst_d_valid", {d_valid, d_done}, 2'b00);
        check("rst_state", o_state, 3'd0);
        check("rst_err", o_err, 1'b0);
        check("rst_ar_fields", {araddr, arlen, arid, arsize, arburst}, 45'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_u_ready", u_ready, 1'b1);

        // Single beat load
        issue(2'b00, 32'h0000_1000, 4'd3, 11'h010);
        ar_phase(0, 32'h0000_1000, 4'd0);
        beat(128'hD0D0_0000_1111_2222_3333_4444_5555_0000, 1'b1, 2'b00, 11'h010);
        check("t1_done_state", o_state, 3'd3);
        check("t1_d_done", d_done, 1'b1);
        tick();
        check("t1_idle", o_state, 3'd0);
        check("t1_d_valid_one_cycle", d_valid, 1'b0);
        check("t1_no_extra_write", ur_we, 1'b0);
        check("t1_u_ready", u_ready, 1'b1);

        // Eight beats, delayed arready, UR address wrap, rvalid gap
        issue(2'b11, 32'h2000_0040, 4'd5, 11'h7FC);
        ar_phase(3, 32'h2000_0040, 4'd7);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                tick();
                check("t2_gap_no_write", ur_we, 1'b0);
            end
            a = 11'h7FC + 11'(i);
            beat({4{32'hC0DE_0000 + 32'(i)}}, (i == 7), 2'b00, a);
        end
        check("t2_done", o_state, 3'd3);
        check("t2_err", o_err, 1'b0);
        tick();
        check("t2_idle", o_state, 3'd0);

        // Error response on beat 2
        issue(2'b10, 32'h0000_3000, 4'd9, 11'h100);
        ar_phase(0, 32'h0000_3000, 4'd3);
        beat(128'h30, 1'b0, 2'b00, 11'h100);
        check("t3_err_clean", o_err, 1'b0);
        beat(128'h31, 1'b0, 2'b10, 11'h101);
        check("t3_err_set", o_err, ERR_EXP);
        beat(128'h32, 1'b0, 2'b00, 11'h102);
        beat(128'h33, 1'b1, 2'b00, 11'h103);
        check("t3_done", o_state, 3'd3);
        tick();
        check("t3_err_held", o_err, ERR_EXP);

        // Early rlast on beat 2
        issue(2'b10, 32'h0000_4000, 4'hA, 11'h200);
        check("t4_err_cleared", o_err, 1'b0);
        ar_phase(0, 32'h0000_4000, 4'd3);
        beat(128'h40, 1'b0, 2'b00, 11'h200);
        beat(128'h41, 1'b1, 2'b00, 11'h201);
        check("t4_early_done", o_state, 3'd3);
        check("t4_err", o_err, ERR_EXP);
        tick();
        check("t4_idle", o_state, 3'd0);
        check("t4_no_third_write", ur_we, 1'b0);
        issue(2'b00, 32'h0000_5000, 4'hB, 11'h300);
        check("t4b_err_cleared", o_err, 1'b0);
        ar_phase(0, 32'h0000_5000, 4'd0);
        beat(128'h50, 1'b1, 2'b00, 11'h300);
        check("t4b_err", o_err, 1'b0);
        tick();

        // u_valid held through the burst
        u_valid = 1'b1; u_brst = 2'b00; u_base = 32'h0000_6000; u_id = 4'd1;
        u_ur_addr = 11'h020; cur_id = 4'd1;
        tick();
        u_base = 32'h0000_7000; u_id = 4'd2; u_ur_addr = 11'h030;
        check("t5_first_accept", o_state, 3'd1);
        check("t5_first_addr", araddr, 32'h0000_6000);
        ar_phase(0, 32'h0000_6000, 4'd0);
        check("t5_busy_rd", u_ready, 1'b0);
        beat(128'h60, 1'b1, 2'b00, 11'h020);
        check("t5_busy_done", u_ready, 1'b0);
        tick();
        check("t5_idle_not_taken", o_state, 3'd0);
        check("t5_ready_idle", u_ready, 1'b1);
        tick();
        u_valid = 1'b0;
        cur_id = 4'd2;
        check("t5_second_accept", o_state, 3'd1);
        check("t5_second_addr", araddr, 32'h0000_7000);
        check("t5_second_id", arid, 4'd2);
        ar_phase(0, 32'h0000_7000, 4'd0);
        beat(128'h70, 1'b1, 2'b00, 11'h030);
        tick();

        // Reset mid-burst, then a clean load
        issue(2'b11, 32'h0000_8000, 4'd4, 11'h040);
        ar_phase(0, 32'h0000_8000, 4'd7);
        beat(128'h80, 1'b0, 2'b00, 11'h040);
        beat(128'h81, 1'b0, 2'b00, 11'h041);
        beat(128'h82, 1'b0, 2'b00, 11'h042);
        rst_n = 1'b0;
        #1;
        check("t6_rst_we", ur_we, 1'b0);
        check("t6_rst_rready", rready, 1'b0);
        check("t6_rst_state", o_state, 3'd0);
        check("t6_rst_addr", ur_addr, 11'h000);
        tick();
        check("t6_rst_hold_we", ur_we, 1'b0);
        rst_n = 1'b1;
        tick();
        check("t6_after_rst_state", o_state, 3'd0);
        issue(2'b00, 32'h0000_9000, 4'd6, 11'h050);
        ar_phase(0, 32'h0000_9000, 4'd0);
        beat(128'h90, 1'b1, 2'b00, 11'h050);
        check("t6_done", d_valid, 1'b1);
        tick();
        check("t6_idle", o_state, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
